// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter in front of one shared registered bitwise logic unit.
// Each transaction runs IDLE -> EXEC -> RESP with registered grant/response.
module gate_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [WIDTH*N_REQ-1:0]   a,
    input  logic [WIDTH*N_REQ-1:0]   b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   idx_r;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;

    logic              found;
    logic [ID_W-1:0]   pick;
    logic [1:0]        op_pick;
    logic [WIDTH-1:0]  a_pick;
    logic [WIDTH-1:0]  b_pick;
    int                cand;

    function automatic logic [WIDTH-1:0] gate_fn(
        input logic [1:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] r;
        unique case (f)
            2'b00:   r = x & z;
            2'b01:   r = x | z;
            2'b10:   r = x ^ z;
            default: r = ~(x & z);
        endcase
        return r;
    endfunction

    // Search requesters starting at ptr, wrapping, and capture the winner's lane.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        op_pick = '0;
        a_pick  = '0;
        b_pick  = '0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                pick    = ID_W'(cand);
                op_pick = op[2*cand +: 2];
                a_pick  = a[WIDTH*cand +: WIDTH];
                b_pick  = b[WIDTH*cand +: WIDTH];
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        if (idx_r == ID_W'(N_REQ - 1)) ptr_nxt = '0;
        else                           ptr_nxt = idx_r + ID_W'(1);
    end

    // Next-state logic: fixed three-cycle cadence once a request is seen.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latched transaction, pointer and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            idx_r     <= '0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            y         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        idx_r <= pick;
                        op_r  <= op_pick;
                        a_r   <= a_pick;
                        b_r   <= b_pick;
                        gnt   <= N_REQ'(1) << pick;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    y         <= gate_fn(op_r, a_r, b_r);
                    rsp_valid <= 1'b1;
                    rsp_id    <= idx_r;
                    ptr       <= ptr_nxt;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: vector table plus hand sequences,
// with a queue scoreboard matching responses to grants.
module tb_gate_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  op  = '0;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  y;

    int n_vec = 0;
    int n_bad = 0;

    logic [1:0] q_id[$];
    logic [3:0] q_y[$];

    typedef struct {
        logic [3:0] req;
        int         sel;
        logic [1:0] opc;
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [3:0] y;
    } vec_t;

    vec_t tbl[9];
    vec_t t5[3];
    vec_t tz;

    gate_unit_arbiter #(.N_REQ(4), .WIDTH(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_chk();
        logic [1:0] eid;
        logic [3:0] ey;
        n_vec++;
        if (q_id.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: got rsp id %0d expected none", rsp_id);
        end else begin
            eid = q_id.pop_front();
            ey  = q_y.pop_front();
            n_vec--;
            chk("rsp_id", 32'(rsp_id), 32'(eid));
            chk("rsp_y", 32'(y), 32'(ey));
        end
    endtask

    task automatic rand_lanes();
        op = 8'($urandom);
        a  = 16'($urandom);
        b  = 16'($urandom);
    endtask

    task automatic apply(input vec_t v);
        int w;
        @(negedge clk);
        rand_lanes();
        op[2*v.sel +: 2] = v.opc;
        a[4*v.sel +: 4]  = v.av;
        b[4*v.sel +: 4]  = v.bv;
        req = v.req;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (gnt == '0 && w < 8);
        chk("gnt", 32'(gnt), 32'(v.gnt));
        chk("gnt_lat", 32'(w), 32'd1);
        chk("busy_exec", 32'(busy), 32'd1);
        if (gnt != '0) begin
            q_id.push_back(v.id);
            q_y.push_back(v.y);
        end
        req = '0;
        rand_lanes();
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 8);
        chk("rsp_lat", 32'(w), 32'd1);
        chk("gnt_pulse", 32'(gnt), 32'd0);
        if (rsp_valid) pop_chk();
        chk("busy_resp", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("y_hold", 32'(y), 32'(v.y));
    endtask

    initial begin
        logic [3:0] eg;
        logic [1:0] eid;

        tbl[0] = '{4'b0010, 1, 2'b01, 4'b1010, 4'b0101, 4'b0010, 2'd1, 4'b1111};
        tbl[1] = '{4'b0001, 0, 2'b00, 4'b1100, 4'b1010, 4'b0001, 2'd0, 4'b1000};
        tbl[2] = '{4'b0001, 0, 2'b01, 4'b1100, 4'b1010, 4'b0001, 2'd0, 4'b1110};
        tbl[3] = '{4'b0001, 0, 2'b10, 4'b1100, 4'b1010, 4'b0001, 2'd0, 4'b0110};
        tbl[4] = '{4'b0001, 0, 2'b11, 4'b1100, 4'b1010, 4'b0001, 2'd0, 4'b0111};
        tbl[5] = '{4'b1001, 3, 2'b10, 4'b1111, 4'b0101, 4'b1000, 2'd3, 4'b1010};
        tbl[6] = '{4'b1001, 0, 2'b11, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b1111};
        tbl[7] = '{4'b0100, 2, 2'b00, 4'b0110, 4'b0011, 4'b0100, 2'd2, 4'b0010};
        tbl[8] = '{4'b0110, 1, 2'b10, 4'b1111, 4'b1111, 4'b0010, 2'd1, 4'b0000};

        t5[0] = '{4'b0010, 1, 2'b10, 4'b0011, 4'b0101, 4'b0010, 2'd1, 4'b0110};
        t5[1] = '{4'b0011, 0, 2'b00, 4'b1111, 4'b1001, 4'b0001, 2'd0, 4'b1001};
        t5[2] = '{4'b0011, 1, 2'b11, 4'b1111, 4'b0011, 4'b0010, 2'd1, 4'b1100};

        tz = '{4'b0101, 0, 2'b01, 4'b0001, 4'b0010, 4'b0001, 2'd0, 4'b0011};

        // reset held with random inputs
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = 4'($urandom);
            rand_lanes();
            #1;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp", 32'(rsp_valid), 32'd0);
            chk("rst_id", 32'(rsp_id), 32'd0);
            chk("rst_y", 32'(y), 32'd0);
        end
        @(negedge clk);
        req = '0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) apply(tbl[i]);

        // all requesters held: grants rotate every 3 cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op  = 8'b01010101;
        a   = {4'd4, 4'd3, 4'd2, 4'd1};
        b   = '0;
        req = 4'b1111;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            eg = (k % 3 == 1) ? 4'(1 << ((k / 3) % 4)) : 4'd0;
            chk("rr_gnt", 32'(gnt), 32'(eg));
            if (gnt != '0) begin
                eid = 2'((k / 3) % 4);
                q_id.push_back(eid);
                q_y.push_back(4'(eid) + 4'd1);
            end
            chk("rr_rsp", 32'(rsp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
            if (rsp_valid) pop_chk();
        end
        req = '0;
        @(negedge clk);

        // wrap after serving requester 1
        for (int i = 0; i < 3; i++) apply(t5[i]);

        // reset during EXEC of requester 2
        @(negedge clk);
        rand_lanes();
        req = 4'b0100;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        req = '0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_y", 32'(y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        apply(tz);

        chk("sb_left", 32'(q_id.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
